// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory / MMIO block: access sizes, I/O region
// offsets, fault causes and the load extension helper.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  localparam logic [31:0] IO_OFF_LED = 32'h0000_0000;
  localparam logic [31:0] IO_OFF_SW  = 32'h0000_0100;
  localparam logic [31:0] IO_OFF_CNT = 32'h0000_0200;

  typedef enum logic [2:0] {
    FC_NONE,
    FC_MISALIGN_HALF,
    FC_MISALIGN_WORD,
    FC_BAD_SIZE,
    FC_UNMAPPED,
    FC_RO_STORE
  } fault_e;

  // Pick the addressed byte/half out of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input size_e sz,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mmio_sync2.sv
// Two-flop synchronizer for asynchronous switch inputs.
module mmio_sync2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Single-cycle data RAM with memory-mapped LEDs, synchronized switches and a
// free-running cycle counter; loads return one cycle after the request.
module data_mem_mmio
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned N_GPIO      = 2,
  parameter logic [31:0] IO_BASE     = 32'hFFFF0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  unsigned_ld,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  rvalid,
  output logic                  fault,
  output logic [8*N_GPIO-1:0]   led_out,
  input  logic [8*N_GPIO-1:0]   sw_in
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [29:0] NG        = 30'(N_GPIO);

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  size_e             sz;
  fault_e            cause;
  logic [29:0]       off_w;
  logic [3:0]        idx;
  logic [AW-1:0]     widx;
  logic              in_ram, in_io, led_hit, sw_hit, cnt_hit, bad;
  logic              led_we, ram_we, lane0;
  logic [31:0]       cnt, io_word, rd_word;
  logic [8*N_GPIO-1:0] sw_s;

  mmio_sync2 #(.WIDTH(8 * N_GPIO)) u_sw_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw_in),
    .q   (sw_s)
  );

  // Word-granular offset into the I/O region; the byte lane comes from addr[1:0].
  assign sz      = size_e'(size);
  assign off_w   = addr[31:2] - IO_BASE[31:2];
  assign idx     = off_w[3:0];
  assign widx    = addr[AW+1:2];
  assign in_ram  = addr < RAM_BYTES;
  assign in_io   = addr >= IO_BASE;
  assign led_hit = in_io && off_w[29:6] == IO_OFF_LED[31:8] && {24'b0, off_w[5:0]} < NG;
  assign sw_hit  = in_io && off_w[29:6] == IO_OFF_SW[31:8]  && {24'b0, off_w[5:0]} < NG;
  assign cnt_hit = in_io && off_w == IO_OFF_CNT[31:2];

  always_comb begin
    cause = FC_NONE;
    if (sz == SZ_BAD)                               cause = FC_BAD_SIZE;
    else if (sz == SZ_HALF && addr[0])              cause = FC_MISALIGN_HALF;
    else if (sz == SZ_WORD && addr[1:0] != 2'b00)   cause = FC_MISALIGN_WORD;
    else if (!(in_ram || led_hit || sw_hit || cnt_hit)) cause = FC_UNMAPPED;
    else if (we && (sw_hit || cnt_hit))             cause = FC_RO_STORE;
  end

  assign bad    = cause != FC_NONE;
  assign lane0  = (sz == SZ_WORD) || (sz == SZ_HALF && !addr[1]) ||
                  (sz == SZ_BYTE && addr[1:0] == 2'b00);
  assign led_we = req && we && !bad && led_hit && lane0;
  assign ram_we = req && we && !bad && in_ram;

  always_comb begin
    io_word = '0;
    for (int unsigned k = 0; k < N_GPIO; k++) begin
      if (led_hit && idx == 4'(k)) io_word = {24'b0, led_out[8*k +: 8]};
      if (sw_hit && idx == 4'(k))  io_word = {24'b0, sw_s[8*k +: 8]};
    end
    if (cnt_hit) io_word = cnt;
  end

  assign rd_word = in_ram ? mem[widx] : io_word;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      case (sz)
        SZ_BYTE: mem[widx][{addr[1:0], 3'b000} +: 8]  <= wdata[7:0];
        SZ_HALF: mem[widx][{addr[1], 4'b0000} +: 16]  <= wdata[15:0];
        default: mem[widx]                            <= wdata;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata   <= '0;
      rvalid  <= 1'b0;
      fault   <= 1'b0;
      led_out <= '0;
      cnt     <= '0;
    end else begin
      cnt    <= cnt + 32'd1;
      rvalid <= req && !we;
      fault  <= req && bad;
      if (req && !we) rdata <= bad ? '0 : load_extend(rd_word, sz, addr[1:0], unsigned_ld);
      for (int unsigned k = 0; k < N_GPIO; k++) begin
        if (led_we && idx == 4'(k)) led_out[8*k +: 8] <= wdata[7:0];
      end
    end
  end

endmodule

// File: doc/data_mem_mmio.md
DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: RAM depth in 32-bit words, power of two.
REQ-002 SHALL have parameter N_GPIO, default 2: number of 8-bit LED/switch channel pairs, range 1..16.
REQ-003 SHALL have parameter IO_BASE, default 32'hFFFF0000: base address of the I/O region.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port req, input, 1: access request this cycle.
REQ-007 SHALL have port we, input, 1: 1 = store, 0 = load; qualified by req.
REQ-008 SHALL have port size, input, 2: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 SHALL have port unsigned_ld, input, 1: zero-extend byte/half loads.
REQ-010 SHALL have port addr, input, 32: byte address.
REQ-011 SHALL have port wdata, input, 32: store data, right-aligned.
REQ-012 SHALL have port rdata, output, 32: registered, extended load data.
REQ-013 SHALL have port rvalid, output, 1: one-cycle pulse marking rdata valid.
REQ-014 SHALL have port fault, output, 1: one-cycle pulse flagging a rejected access.
REQ-015 SHALL have port led_out, output, 8*N_GPIO: LED registers; channel k at bits [8k+7:8k].
REQ-016 SHALL have port sw_in, input, 8*N_GPIO: asynchronous switch inputs, same packing.

Function
REQ-017 SHALL map RAM at 0 .. 4*DEPTH_WORDS-1; LED k at IO_BASE+4k (R/W); switch k at IO_BASE+0x100+4k (RO); cycle counter at IO_BASE+0x200 (RO).
REQ-018 SHALL accept one request per cycle with no stall; req held high over N cycles yields N accesses.
REQ-019 SHALL commit stores at the rising edge ending the request cycle.
REQ-020 SHALL byte-lane stores: byte writes wdata[7:0] to lane addr[1:0]; half writes wdata[15:0] to lanes selected by addr[1]; other lanes unchanged.
REQ-021 SHALL return load data on rdata with rvalid high exactly one cycle after req&!we; rdata holds between pulses.
REQ-022 SHALL extract the addressed byte/half and sign-extend unless unsigned_ld=1; word loads are unmodified.
REQ-023 SHALL return the new value on a load issued the cycle after a store to the same address.
REQ-024 SHALL fault on: misaligned half (addr[0]=1); misaligned word (addr[1:0]!=0); size=11; unmapped address; store to switch or counter addresses.
REQ-025 SHALL, on a faulting access: perform no state change; pulse fault one cycle later; for loads also pulse rvalid with rdata=0.
REQ-026 SHALL load LED k from wdata[7:0] on any aligned store to IO_BASE+4k with lane 0 selected; byte stores to lanes 1-3 are ignored without fault.
REQ-027 SHALL return {24'b0, LED k} on LED reads and {24'b0, synchronized switch k} on switch reads.
REQ-028 SHALL synchronize sw_in through two flops per bit; a load reflects sw_in as sampled two edges before the request cycle.
REQ-029 SHALL increment the 32-bit counter every cycle and wrap from 32'hFFFFFFFF to 0.

Reset
REQ-030 SHALL, when rst asserts, immediately clear rdata, rvalid, fault, led_out, synchronizer flops and counter to 0, independent of clk.
REQ-031 SHALL drop an in-flight load when rst asserts mid-operation; no rvalid pulse follows reset deassertion.
REQ-032 SHALL not clear RAM on reset; RAM initializes to 0 at simulation start only.

Structure
REQ-033 SHALL place size encodings, I/O offsets (0x000, 0x100, 0x200) and the fault-cause list in shared package data_mem_pkg.
REQ-034 SHALL implement the switch synchronizer as sub-module mmio_sync2, parametrised by width.

Verification
REQ-035 SHALL cover: sw 0x12345678 @0x10, then lb @0x11 -> rdata 0x00000056 one cycle later; lh @0x12 -> 0x00001234.
REQ-036 SHALL cover: sb 0x80 @0x20 into zeroed word, then lb -> 0xFFFFFF80, lbu -> 0x00000080, lw -> 0x00000080.
REQ-037 SHALL cover: lw @0x22 -> fault and rvalid pulse, rdata 0; sh @0x21 -> fault pulse, RAM unchanged.
REQ-038 SHALL cover: store 0xA5 to IO_BASE+4 -> led_out[15:8]=0xA5; sw_in[7:0]=0x3C, load IO_BASE+0x100 three cycles later -> 0x0000003C.
REQ-039 SHALL cover: rst pulse while a load is in flight -> rvalid stays 0; led_out=0; counter reads 0 or 1 at first post-reset load.
